// File: rtl/fir_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_seq_pkg
//  Description : Shared definitions for the FIR frame sequencer: the
//                sequencer state type, the frame counter width and the
//                flush-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_seq_pkg;

    // Sequencer states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } seq_state_e;

    // Width of the completed-frame counter.
    localparam int unsigned c_FRAME_CNT_W = 16;

    // Width of the flush down-counter, which must hold NUM_TAPS-1.
    function automatic int unsigned flush_cnt_width(input int unsigned num_taps);
        if (num_taps < 2) begin
            return 1;
        end
        return $clog2(num_taps);
    endfunction

endpackage : fir_seq_pkg
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_reg
//  Description : Single-entry AXI-Stream output register. It loads a new
//                beat whenever it is empty or its current beat is being
//                accepted downstream; otherwise tdata/tlast hold stable.
//  Ports       : clk_i/rst_ni   - clock, asynchronous active-low reset
//                in_valid_i     - a beat is offered for loading
//                in_data_i      - beat data
//                in_last_i      - beat tlast
//                out_ready_i    - downstream ready
//                out_valid_o    - registered valid
//                out_data_o     - registered data
//                out_last_o     - registered tlast
//                load_en_o      - register will take in_* at the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              load_en_o
);

    logic              r_valid_q;
    logic [DATA_W-1:0] r_data_q;
    logic              r_last_q;
    logic              w_load_en;

    // Empty, or the current beat leaves this cycle.
    assign w_load_en = !r_valid_q || out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_last_q  <= 1'b0;
        end else if (w_load_en) begin
            r_valid_q <= in_valid_i;
            r_data_q  <= in_data_i;
            r_last_q  <= in_last_i;
        end
    end

    assign out_valid_o = r_valid_q;
    assign out_data_o  = r_data_q;
    assign out_last_o  = r_last_q;
    assign load_en_o   = w_load_en;

endmodule : axis_out_reg
`default_nettype wire

// File: rtl/fir_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_sequencer
//  Description : Frame controller in front of a NUM_TAPS-tap FIR. Forwards
//                each upstream frame, then injects NUM_TAPS-1 zero beats to
//                drain the FIR tail, marking the last zero with tlast.
//                Frames longer than MAX_FRAME_LEN are force-terminated and
//                flagged through the sticky err_overlong.
//  Config      : FIR_SEQ_FRAME_CNT_EN - when defined, frame_count is a
//                16-bit wrapping count of completed frames; otherwise it is
//                tied to zero.
//  Ports       : s00_axis_aclk     - clock
//                s00_axis_aresetn  - asynchronous active-low reset
//                s00_axis_*        - upstream AXI-Stream slave
//                m00_axis_*        - downstream AXI-Stream master (to FIR)
//                busy              - frame or flush in progress
//                err_overlong      - sticky, a frame was truncated
//                frame_count       - completed frames
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned NUM_TAPS               = 15,
    parameter int unsigned MAX_FRAME_LEN          = 1024
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    output logic                              s00_axis_tready,
    output logic                              m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic                              busy,
    output logic                              err_overlong,
    output logic [c_FRAME_CNT_W-1:0]          frame_count
);

    localparam int unsigned c_SAMP_W  = $clog2(MAX_FRAME_LEN + 1);
    localparam int unsigned c_FLUSH_W = flush_cnt_width(NUM_TAPS);
    localparam logic [c_SAMP_W-1:0]  c_MAX_LEN   = c_SAMP_W'(MAX_FRAME_LEN);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LEN = c_FLUSH_W'(NUM_TAPS - 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE = c_FLUSH_W'(1);

    seq_state_e                  r_state_q, w_state_d;
    logic [c_SAMP_W-1:0]         r_samp_q,  w_samp_d;
    logic [c_FLUSH_W-1:0]        r_flush_q, w_flush_d;
    logic                        r_err_q,   w_err_d;

    logic [c_SAMP_W-1:0]               w_samp_inc;
    logic                              w_load_en;
    logic                              w_s_hs;
    logic                              w_last_hs;
    logic                              w_ld_valid;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_ld_data;
    logic                              w_ld_last;

    // Gated by reset so that every output reads 0 while reset is held.
    assign s00_axis_tready = s00_axis_aresetn && (r_state_q != FLUSH) && w_load_en;
    assign w_s_hs          = s00_axis_tvalid && s00_axis_tready;
    assign w_last_hs       = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
    assign w_samp_inc      = r_samp_q + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state_q <= IDLE;
            r_samp_q  <= '0;
            r_flush_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_samp_q  <= w_samp_d;
            r_flush_q <= w_flush_d;
            r_err_q   <= w_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output-register load logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_samp_d   = r_samp_q;
        w_flush_d  = r_flush_q;
        w_err_d    = r_err_q;
        w_ld_valid = 1'b0;
        w_ld_data  = '0;
        w_ld_last  = 1'b0;

        unique case (r_state_q)
            IDLE, PASS: begin
                if (w_s_hs) begin
                    w_ld_valid = 1'b1;
                    w_ld_data  = C_M00_AXIS_TDATA_WIDTH'(s00_axis_tdata);
                    if (s00_axis_tlast || (w_samp_inc == c_MAX_LEN)) begin
                        // Real or forced end of frame: arm the flush.
                        w_state_d = FLUSH;
                        w_samp_d  = '0;
                        w_flush_d = c_FLUSH_LEN;
                        if (!s00_axis_tlast) begin
                            w_err_d = 1'b1;
                        end
                    end else begin
                        w_state_d = PASS;
                        w_samp_d  = w_samp_inc;
                    end
                end
            end
            FLUSH: begin
                if (r_flush_q != '0) begin
                    // Emit one zero per free register slot; backpressure
                    // stalls the count so no zero is lost or repeated.
                    if (w_load_en) begin
                        w_ld_valid = 1'b1;
                        w_ld_last  = (r_flush_q == c_FLUSH_ONE);
                        w_flush_d  = r_flush_q - 1'b1;
                    end
                end else if (w_last_hs) begin
                    // All zeros issued; leave once the tlast beat is taken.
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    axis_out_reg #(
        .DATA_W (C_M00_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .clk_i       (s00_axis_aclk),
        .rst_ni      (s00_axis_aresetn),
        .in_valid_i  (w_ld_valid),
        .in_data_i   (w_ld_data),
        .in_last_i   (w_ld_last),
        .out_ready_i (m00_axis_tready),
        .out_valid_o (m00_axis_tvalid),
        .out_data_o  (m00_axis_tdata),
        .out_last_o  (m00_axis_tlast),
        .load_en_o   (w_load_en)
    );

    // ------------------------------------------------------------------
    // Completed-frame counter
    // ------------------------------------------------------------------
`ifdef FIR_SEQ_FRAME_CNT_EN
    logic [c_FRAME_CNT_W-1:0] r_frame_cnt_q;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_frame_cnt_q <= '0;
        end else if (w_last_hs) begin
            r_frame_cnt_q <= r_frame_cnt_q + 1'b1;
        end
    end

    assign frame_count = r_frame_cnt_q;
`else
    assign frame_count = '0;
`endif

    assign busy         = (r_state_q != IDLE);
    assign err_overlong = r_err_q;

endmodule : fir_frame_sequencer
`default_nettype wire
